// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared lane count, lane index and FSM state types for the round-robin mux arbiter
package rr_arb_pkg;
  localparam int N_LANES = 4;
  typedef logic [1:0] lane_idx_t;
  typedef enum logic {IDLE, BURST} arb_state_t;
endpackage

// File: rtl/rr_pick_4.sv
// rr_pick_4: first valid lane scanning cyclically from start
module rr_pick_4
  import rr_arb_pkg::*;
(
  input  logic [N_LANES-1:0] valid,
  input  lane_idx_t          start,
  output logic               any,
  output lane_idx_t          idx
);
  logic [N_LANES-1:0] rot;
  lane_idx_t off;
  always_comb begin
    rot = 4'({valid, valid} >> start);
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    any = |valid;
    idx = start + off;
  end
endmodule

// File: rtl/rr_mux_arbiter_4.sv
// rr_mux_arbiter_4: round-robin burst arbiter sharing one registered W-bit channel among four valid/ready lanes
module rr_mux_arbiter_4
  import rr_arb_pkg::*;
#(
  parameter int W         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_LANES-1:0]          in_valid,
  input  logic [N_LANES-1:0][W-1:0]   in_data,
  output logic [N_LANES-1:0]          in_ready,
  output logic                        out_valid,
  output logic [W-1:0]                out_data,
  output lane_idx_t                   out_src,
  input  logic                        out_ready
);
  arb_state_t state;
  lane_idx_t ptr, owner, pick_start, pick_idx, g;
  logic [3:0] cnt;
  logic can_load, hold, pick_any, load, last;
  assign can_load   = !out_valid || out_ready;
  assign hold       = state == BURST && in_valid[owner];
  assign pick_start = state == BURST ? owner + 2'd1 : ptr;
  assign g          = hold ? owner : pick_idx;
  assign load       = rst_n && can_load && (hold || pick_any);
  assign last       = hold ? cnt + 4'd1 == 4'(MAX_BURST) : MAX_BURST == 1;
  assign in_ready   = load ? 4'b0001 << g : 4'b0000;
  rr_pick_4 u_pick (
    .valid (in_valid),
    .start (pick_start),
    .any   (pick_any),
    .idx   (pick_idx)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (can_load) begin
      out_valid <= load;
      if (load) begin
        out_data <= in_data[g];
        out_src  <= g;
        owner    <= g;
        cnt      <= hold ? cnt + 4'd1 : 4'd1;
        state    <= last ? IDLE : BURST;
        if (last) ptr <= g + 2'd1;
      end else if (state == BURST) begin
        state <= IDLE;
        ptr   <= owner + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// tb_rr_mux_arbiter_4: directed and randomized checks of two arbiter instances (MAX_BURST 1 and 4) against a lane-level model
module tb_rr_mux_arbiter_4;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] in_valid;
  logic [3:0][3:0] in_data;
  logic out_ready;
  logic [3:0] rdy1, rdy4;
  logic ov1, ov4;
  logic [3:0] od1, od4;
  logic [1:0] os1, os4;
  logic chk_en = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int m_hold[2] = '{-1, -1};
  int m_ptr[2] = '{0, 0};
  int m_beats[2] = '{0, 0};
  int m_os[2] = '{0, 0};
  logic m_ov[2] = '{1'b0, 1'b0};
  logic [3:0] m_od[2] = '{4'h0, 4'h0};
  int r1[5] = '{0, 1, 2, 3, 0};
  int q4[5] = '{0, 0, 0, 0, 1};
  int b4[9] = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
  int b1[9] = '{1, 2, 1, 2, 1, 2, 1, 2, 1};
  int e4[4] = '{3, 3, 0, 0};
  always #5 clk = ~clk;
  rr_mux_arbiter_4 #(.W(4), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
    .out_valid(ov1), .out_data(od1), .out_src(os1), .out_ready(out_ready)
  );
  rr_mux_arbiter_4 #(.W(4), .MAX_BURST(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy4),
    .out_valid(ov4), .out_data(od4), .out_src(os4), .out_ready(out_ready)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_step(input int k, input int mb, input string tag, input logic [3:0] rdy,
                            input logic ov, input logic [3:0] od, input logic [1:0] os);
    int g, s;
    logic can;
    logic [3:0] er;
    can = !m_ov[k] || out_ready;
    g = -1;
    if (rst_n && can) begin
      if (m_hold[k] >= 0 && in_valid[m_hold[k]]) g = m_hold[k];
      else begin
        s = m_hold[k] >= 0 ? (m_hold[k] + 1) % 4 : m_ptr[k];
        for (int j = 0; j < 4; j++) if (g < 0 && in_valid[(s + j) % 4]) g = (s + j) % 4;
      end
    end
    er = g >= 0 ? 4'(1 << g) : 4'd0;
    if (chk_en) begin
      chk({tag, " in_ready"}, rdy, er);
      chk({tag, " out_valid"}, ov, m_ov[k]);
      chk({tag, " out_data"}, od, m_od[k]);
      chk({tag, " out_src"}, os, m_os[k]);
    end
    if (!rst_n) begin
      m_hold[k] = -1; m_ptr[k] = 0; m_beats[k] = 0;
      m_ov[k] = 1'b0; m_od[k] = '0; m_os[k] = 0;
    end else if (can) begin
      if (g >= 0) begin
        m_od[k] = in_data[g];
        m_os[k] = g;
        m_ov[k] = 1'b1;
        m_beats[k] = g == m_hold[k] ? m_beats[k] + 1 : 1;
        if (m_beats[k] == mb) begin
          m_ptr[k] = (g + 1) % 4;
          m_hold[k] = -1;
        end else m_hold[k] = g;
      end else begin
        m_ov[k] = 1'b0;
        if (m_hold[k] >= 0) m_ptr[k] = (m_hold[k] + 1) % 4;
        m_hold[k] = -1;
      end
    end
  endtask
  always @(negedge clk) begin
    model_step(0, 1, "b1", rdy1, ov1, od1, os1);
    model_step(1, 4, "b4", rdy4, ov4, od4, os4);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_chk();
    #1;
    chk("reset in_ready", rdy4, 4'b0000);
    chk("reset out_valid", ov4, 1'b0);
    chk("reset out_data", od4, 4'h0);
    chk("reset in_ready b1", rdy1, 4'b0000);
  endtask
  initial begin
    rst_n = 1'b0;
    in_valid = 4'hF;
    out_ready = 1'b1;
    in_data = {4'hD, 4'hC, 4'hB, 4'hA};
    cyc();
    chk_en = 1'b1;
    reset_chk();
    cyc();
    reset_chk();
    rst_n = 1'b1;
    #1;
    chk("first grant b4", rdy4, 4'b0001);
    chk("first grant b1", rdy1, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rotation src", os1, r1[i]);
      chk("rotation data", od1, 4'hA + r1[i]);
      chk("rotation valid", ov1, 1'b1);
      chk("burst4 first src", os4, q4[i]);
    end
    rst_n = 1'b0;
    cyc();
    chk("midburst reset out_valid", ov4, 1'b0);
    chk("midburst reset out_data", od4, 4'h0);
    rst_n = 1'b1;
    in_valid = 4'b0110;
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk("burst limit src", os4, b4[i]);
      chk("burst1 alt src", os1, b1[i]);
    end
    rst_n = 1'b0;
    in_valid = 4'b1000;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("early release src", os4, e4[i]);
      chk("early release valid", ov4, 1'b1);
      in_valid = i == 0 ? 4'b1001 : 4'b0001;
    end
    out_ready = 1'b0;
    in_data[0] = 4'h7;
    #1;
    chk("stall in_ready", rdy4, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall src", os4, 2'd0);
      chk("stall data", od4, 4'hA);
      chk("stall valid", ov4, 1'b1);
      chk("stall in_ready", rdy4, 4'b0000);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall in_ready", rdy4, 4'b0001);
    cyc();
    chk("unstall data", od4, 4'h7);
    chk("unstall valid", ov4, 1'b1);
    rst_n = 1'b0;
    in_valid = 4'b0000;
    cyc();
    rst_n = 1'b1;
    in_data = {4'hD, 4'h5, 4'hB, 4'hA};
    in_valid = 4'b0100;
    cyc();
    chk("drain valid", ov4, 1'b1);
    chk("drain data", od4, 4'h5);
    chk("drain src", os4, 2'd2);
    in_valid = 4'b0000;
    cyc();
    chk("drain gone", ov4, 1'b0);
    cyc();
    chk("drain still gone", ov4, 1'b0);
    chk("drain data held", od4, 4'h5);
    in_valid = 4'b1100;
    #1;
    chk("after drain grant b4", rdy4, 4'b1000);
    chk("after drain grant b1", rdy1, 4'b1000);
    cyc();
    chk("after drain src", os4, 2'd3);
    for (int i = 0; i < 400; i++) begin
      in_valid = 4'($urandom);
      in_data = 16'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      rst_n = $urandom_range(0, 99) != 0;
      cyc();
    end
    rst_n = 1'b1;
    cyc();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
